// File: rtl/sobel_master_engine_if.sv
// Avalon-MM master bus between the Sobel engine and memory.
// Zero-latency, non-pipelined reads: readdata is valid while read=1 and waitrequest=0.
interface sobel_master_engine_if #(
  parameter int AW = 16,
  parameter int DW = 16
) ();
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic          waitrequest;
  logic [DW-1:0] readdata;
  logic [DW-1:0] writedata;

  modport master (output address, read, write, writedata, input waitrequest, readdata);
  modport slave  (input address, read, write, writedata, output waitrequest, readdata);
endinterface

// File: rtl/sobel_master_engine.sv
// Sobel gradient engine: fetches each interior pixel's 3x3 neighbourhood over
// Avalon-MM, computes |Gx|+|Gy| saturated to 8 bits and writes one word per pixel.
module sobel_master_engine #(
  parameter int IMG_W             = 32,
  parameter int IMG_H             = 32,
  parameter int AVM_DATA_WIDTH    = 16,
  parameter int AVM_ADDRESS_WIDTH = 16
) (
  input  logic        CSI_CLOCK_CLK,
  input  logic        CSI_CLOCK_RESET,
  input  logic        go,
  input  logic [15:0] inputAdd_offset,
  input  logic [15:0] outputAdd_offset,
  output logic        done,
  output logic        busy,
  sobel_master_engine_if.master avm
);
  localparam int AW = AVM_ADDRESS_WIDTH;
  localparam int DW = AVM_DATA_WIDTH;
  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_CALC  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state;
  logic          go_d;
  logic [AW-1:0] in_base, out_base;
  logic [RW-1:0] r;
  logic [CW-1:0] c;
  logic [1:0]    kr, kc;   // tap row/column inside the 3x3 window
  logic [3:0]    k;
  logic [7:0]    p [9];
  logic [7:0]    mag;

  logic [AW-1:0]       rd_addr, wr_addr;
  logic signed [11:0]  gx, gy;
  logic [11:0]         ax, ay, msum;
  logic [7:0]          mag_sat;
  logic                last_px;

  function automatic logic signed [11:0] px(input logic [7:0] v);
    return $signed({4'b0000, v});
  endfunction

  assign k       = {2'b00, kr} * 4'd3 + {2'b00, kc};
  assign last_px = (r == RW'(IMG_H - 2)) && (c == CW'(IMG_W - 2));

  assign rd_addr = in_base + (AW'(r) + AW'(kr) - AW'(1)) * AW'(IMG_W) + AW'(c) + AW'(kc) - AW'(1);
  assign wr_addr = out_base + AW'(r) * AW'(IMG_W) + AW'(c);

  always_comb begin
    gx      = (px(p[2]) + (px(p[5]) <<< 1) + px(p[8])) - (px(p[0]) + (px(p[3]) <<< 1) + px(p[6]));
    gy      = (px(p[6]) + (px(p[7]) <<< 1) + px(p[8])) - (px(p[0]) + (px(p[1]) <<< 1) + px(p[2]));
    ax      = gx[11] ? 12'(-gx) : 12'(gx);
    ay      = gy[11] ? 12'(-gy) : 12'(gy);
    msum    = ax + ay;
    mag_sat = (msum > 12'd255) ? 8'hFF : msum[7:0];
  end

  // Bus outputs decode straight from state so a reset drops them at once.
  always_comb begin
    avm.read      = (state == S_READ);
    avm.write     = (state == S_WRITE);
    avm.address   = '0;
    avm.writedata = '0;
    if (state == S_READ)  avm.address = rd_addr;
    if (state == S_WRITE) begin
      avm.address   = wr_addr;
      avm.writedata = DW'(mag);
    end
    done = (state == S_DONE);
    busy = (state != S_IDLE);
  end

  always_ff @(posedge CSI_CLOCK_CLK or posedge CSI_CLOCK_RESET) begin
    if (CSI_CLOCK_RESET) begin
      state    <= S_IDLE;
      go_d     <= 1'b0;
      in_base  <= '0;
      out_base <= '0;
      r        <= '0;
      c        <= '0;
      kr       <= '0;
      kc       <= '0;
      mag      <= '0;
      for (int i = 0; i < 9; i++) p[i] <= '0;
    end else begin
      go_d <= go;
      case (state)
        S_IDLE: if (go && !go_d) begin
          in_base  <= AW'(inputAdd_offset);
          out_base <= AW'(outputAdd_offset);
          r        <= RW'(1);
          c        <= CW'(1);
          kr       <= '0;
          kc       <= '0;
          state    <= S_READ;
        end
        S_READ: if (!avm.waitrequest) begin
          p[k] <= avm.readdata[7:0];
          if (kr == 2'd2 && kc == 2'd2) state <= S_CALC;
          else if (kc == 2'd2) begin
            kc <= '0;
            kr <= kr + 2'd1;
          end else kc <= kc + 2'd1;
        end
        S_CALC: begin
          mag   <= mag_sat;
          state <= S_WRITE;
        end
        S_WRITE: if (!avm.waitrequest) begin
          if (last_px) state <= S_DONE;
          else begin
            if (c == CW'(IMG_W - 2)) begin
              c <= CW'(1);
              r <= r + RW'(1);
            end else c <= c + CW'(1);
            kr    <= '0;
            kc    <= '0;
            state <= S_READ;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sobel_master_engine.sv
// Randomized bench for sobel_master_engine on a 4x4 image against a queue-based reference model.
module tb_sobel_master_engine;
  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic [15:0] in_off = '0, out_off = '0;
  logic        done, busy;
  logic        wreq = 1'b0;
  logic [7:0]  junk = '0;
  logic [7:0]  mem [65536];

  sobel_master_engine_if #(.AW(16), .DW(16)) bus ();
  assign bus.waitrequest = wreq;
  assign bus.readdata    = {junk, mem[bus.address]};

  sobel_master_engine #(.IMG_W(W), .IMG_H(H), .AVM_DATA_WIDTH(16), .AVM_ADDRESS_WIDTH(16)) dut (
    .CSI_CLOCK_CLK(clk), .CSI_CLOCK_RESET(rst), .go(go),
    .inputAdd_offset(in_off), .outputAdd_offset(out_off),
    .done(done), .busy(busy), .avm(bus.master));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int t0 = -1, done_at = 0, done_cnt = 0;
  bit expect_run = 0, rand_wait = 0;
  int rd_stall = 0, wr_stall = 0;
  logic [15:0] exp_rd [$];
  logic [31:0] exp_wr [$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pix(input logic [15:0] b, input int x, input int y);
    logic [15:0] a;
    a = b + 16'(y * W + x);
    return int'(mem[a]);
  endfunction

  // Reference: expected read addresses and (address,data) writes, straight from the Sobel definition.
  task automatic prep(input logic [15:0] ib, input logic [15:0] ob, input int mode);
    int gx, gy, m;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        logic [15:0] a;
        a = ib + 16'(y * W + x);
        case (mode)
          0: mem[a] = (x >= 2) ? 8'd10 : 8'd0;
          1: mem[a] = 8'd77;
          2: mem[a] = (x == 1) ? 8'd255 : 8'd0;
          3: mem[a] = 8'($urandom);
          default: mem[a] = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
        endcase
      end
    exp_rd.delete();
    exp_wr.delete();
    for (int r = 1; r < H - 1; r++)
      for (int c = 1; c < W - 1; c++) begin
        for (int k = 0; k < 9; k++) exp_rd.push_back(ib + 16'((r - 1 + k / 3) * W + (c - 1 + k % 3)));
        gx = (pix(ib, c+1, r-1) + 2*pix(ib, c+1, r) + pix(ib, c+1, r+1))
           - (pix(ib, c-1, r-1) + 2*pix(ib, c-1, r) + pix(ib, c-1, r+1));
        gy = (pix(ib, c-1, r+1) + 2*pix(ib, c, r+1) + pix(ib, c+1, r+1))
           - (pix(ib, c-1, r-1) + 2*pix(ib, c, r-1) + pix(ib, c+1, r-1));
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > 255) m = 255;
        exp_wr.push_back({ob + 16'(r * W + c), 16'(m)});
      end
  endtask

  task automatic start(input logic [15:0] ib, input logic [15:0] ob, input int rs, input int ws, input bit rw);
    rd_stall = rs; wr_stall = ws; rand_wait = rw;
    in_off = ib; out_off = ob;
    t0 = -1; done_cnt = 0; expect_run = 1;
    go = 1'b0;
    @(posedge clk); #1;
    go = 1'b1;
  endtask

  task automatic wait_done(input int exp_done);
    int i;
    i = 0;
    while (done_cnt == 0 && i < 3000) begin @(posedge clk); i++; end
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", done_cnt, 1);
    chk("reads_left", exp_rd.size(), 0);
    chk("writes_left", exp_wr.size(), 0);
    chk("busy_after", busy, 0);
    if (exp_done >= 0) chk("done_cycle", done_at, exp_done);
    expect_run = 0;
  endtask

  // Slave driver + compare process, both on the falling edge.
  logic        p_rs = 0, p_ws = 0;
  logic [15:0] p_addr = '0, p_data = '0;
  initial forever begin
    @(negedge clk);
    cyc++;
    junk = 8'($urandom);
    if (!rst && bus.read && rd_stall > 0) begin wreq = 1'b1; rd_stall--; end
    else if (!rst && bus.write && wr_stall > 0) begin wreq = 1'b1; wr_stall--; end
    else wreq = rand_wait ? ($urandom_range(0, 3) == 0) : 1'b0;
    if (!rst) begin
      chk("rd_wr_exclusive", int'(bus.read & bus.write), 0);
      if (p_rs) begin chk("stall_read", bus.read, 1); chk("stall_rd_addr", bus.address, p_addr); end
      if (p_ws) begin
        chk("stall_write", bus.write, 1);
        chk("stall_wr_addr", bus.address, p_addr);
        chk("stall_wr_data", bus.writedata, p_data);
      end
      if (bus.read && t0 < 0) t0 = cyc;
      if (bus.read && !wreq) begin
        if (exp_rd.size() == 0) chk("read_extra", 1, 0);
        else chk("read_addr", bus.address, exp_rd.pop_front());
      end
      if (bus.write && !wreq) begin
        if (exp_wr.size() == 0) chk("write_extra", 1, 0);
        else begin
          logic [31:0] e;
          e = exp_wr.pop_front();
          chk("write_addr", bus.address, e[31:16]);
          chk("write_data", bus.writedata, e[15:0]);
        end
      end
      if (done) begin
        done_cnt++;
        done_at = cyc - t0;
        chk("done_busy", busy, 1);
        chk("done_expected", expect_run, 1);
      end
    end
    p_rs   = !rst && bus.read && wreq;
    p_ws   = !rst && bus.write && wreq;
    p_addr = bus.address;
    p_data = bus.writedata;
  end

  initial begin
    int i;
    #12;
    chk("rst_read", bus.read, 0);
    chk("rst_write", bus.write, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", bus.address, 0);
    chk("rst_wdata", bus.writedata, 0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);

    // Test 1: step edge, model pinned by hand-computed values.
    prep(16'h0100, 16'h0200, 0);
    chk("model_rd0", exp_rd[0], 16'h0100);
    chk("model_wr0", exp_wr[0], 32'h0205_0028);
    chk("model_wr1", exp_wr[1], 32'h0206_0028);
    chk("model_wr2", exp_wr[2], 32'h0209_0028);
    chk("model_wr3", exp_wr[3], 32'h020A_0028);
    start(16'h0100, 16'h0200, 0, 0, 0);
    wait_done(44);

    // Test 2: flat image.
    prep(16'h0100, 16'h0200, 1);
    chk("model_flat", exp_wr[2], 32'h0209_0000);
    start(16'h0100, 16'h0200, 0, 0, 0);
    wait_done(44);

    // Test 3: bright column, saturation.
    prep(16'h0100, 16'h0200, 2);
    chk("model_sat_a", exp_wr[0], 32'h0205_0000);
    chk("model_sat_b", exp_wr[1], 32'h0206_00FF);
    chk("model_sat_c", exp_wr[3], 32'h020A_00FF);
    start(16'h0100, 16'h0200, 0, 0, 0);
    wait_done(44);

    // Test 4: scripted stalls on first read and first write.
    prep(16'h0100, 16'h0200, 0);
    start(16'h0100, 16'h0200, 3, 2, 0);
    wait_done(49);

    // Test 5: go re-edge and offset changes mid-run are ignored; then a fresh run.
    prep(16'h0100, 16'h0200, 3);
    start(16'h0100, 16'h0200, 0, 0, 0);
    repeat (10) @(posedge clk);
    #1; in_off = 16'h3000; out_off = 16'h4000; go = 1'b0;
    @(posedge clk); #1; go = 1'b1;
    wait_done(44);
    prep(16'h3000, 16'h4000, 3);
    start(16'h3000, 16'h4000, 0, 0, 0);
    wait_done(44);

    // Randomized images, bases (including wrap) and wait states.
    for (int n = 0; n < 6; n++) begin
      logic [15:0] ib, ob;
      ib = (n % 2 == 0) ? 16'($urandom_range(16'hFFF4, 16'hFFFF)) : 16'($urandom);
      ob = 16'($urandom);
      prep(ib, ob, 3 + (n % 2));
      start(ib, ob, 0, 0, 1);
      wait_done(-1);
    end

    // Test 6: reset during pixel 2's reads, restart with go still high.
    prep(16'h0100, 16'h0200, 3);
    start(16'h0100, 16'h0200, 0, 0, 0);
    i = 0;
    while (exp_wr.size() > 2 && i < 500) begin @(posedge clk); i++; end
    chk("pre_rst_writes", exp_wr.size(), 2);
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    chk("pre_rst_read", bus.read, 1);
    rst = 1'b1; expect_run = 0;
    #1;
    chk("arst_read", bus.read, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_addr", bus.address, 0);
    repeat (2) @(posedge clk);
    prep(16'h0100, 16'h0200, 3);
    t0 = -1; done_cnt = 0; expect_run = 1;
    @(negedge clk); rst = 1'b0;
    wait_done(44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
